// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/DECODE/EXEC/HALT sequencer with the program counter and
// the instruction register.
module fetch_unit #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IW   = 12
) (
  input  logic            clk,
  input  logic            CLB,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [IW-1:0]   mem_rdata,
  input  logic            IncPC,
  input  logic            SelPC,
  input  logic            LoadPC,
  input  logic [PC_W-1:0] reg_data,
  output logic [3:0]      Opcode,
  output logic [PC_W-1:0] Operand,
  output logic [3:0]      RegAddr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

  state_e          state_q, state_d;
  logic            run_q;
  logic            load_ir;
  logic [IW-1:0]   ir_q;
  logic [PC_W-1:0] pc_q, pc_d;

  // run_q keeps mem_req low until the first edge after CLB is released.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    load_ir = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_req && mem_ack) begin
          state_d = StDecode;
          load_ir = 1'b1;
        end
      end
      StDecode: state_d = StExec;
      StExec:   state_d = (Opcode == 4'hF) ? StHalt : StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    mem_req     = run_q && (state_q == StFetch);
    instr_valid = (state_q == StExec);
    halted      = (state_q == StHalt);
  end

  always_comb begin
    pc_d = pc_q;
    if (state_q == StExec && Opcode != 4'hF) begin
      if (LoadPC) begin
        pc_d = SelPC ? reg_data : Operand;
      end else if (IncPC) begin
        pc_d = pc_q + PC_W'(1);
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      ir_q <= '0;
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (load_ir) begin
        ir_q <= mem_rdata;
      end
    end
  end

  assign Opcode   = ir_q[IW-1 -: 4];
  assign Operand  = ir_q[PC_W-1:0];
  assign RegAddr  = ir_q[3:0];
  assign mem_addr = pc_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table of instructions with a scoreboard,
// plus hand-written halt and asynchronous-clear sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        CLB = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [11:0] mem_rdata = '0;
  logic        IncPC = 1'b0;
  logic        SelPC = 1'b0;
  logic        LoadPC = 1'b0;
  logic [7:0]  reg_data = '0;
  logic [3:0]  Opcode;
  logic [7:0]  Operand;
  logic [3:0]  RegAddr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;

  fetch_unit #(.PC_W(8), .IW(12)) dut (
    .clk         (clk),
    .CLB         (CLB),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .IncPC       (IncPC),
    .SelPC       (SelPC),
    .LoadPC      (LoadPC),
    .reg_data    (reg_data),
    .Opcode      (Opcode),
    .Operand     (Operand),
    .RegAddr     (RegAddr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] instr;
    int          waits;
    logic        load;
    logic        sel;
    logic        inc;
    logic [7:0]  rdata;
  } vec_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] opnd;
    logic [3:0] ra;
    logic [7:0] npc;
  } sb_t;

  sb_t        sbq[$];
  vec_t       vecs[10];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mpc = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_npc(input logic [7:0] p, input vec_t v);
    logic [7:0] opnd;
    opnd = v.instr[7:0];
    if (v.instr[11:8] == 4'hF) return p;
    if (v.load) return v.sel ? v.rdata : opnd;
    return p + 8'd1;
  endfunction

  // Entered and left at a falling edge with the DUT in FETCH.
  task automatic run_vec(input vec_t v);
    int         n;
    sb_t        e;
    logic [3:0] prev_op;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_addr", {24'd0, mem_addr}, {24'd0, mpc});
    prev_op  = Opcode;
    // Controls driven outside EXEC must be ignored.
    LoadPC   = 1'b1;
    SelPC    = 1'b1;
    IncPC    = 1'b1;
    reg_data = 8'hAA;
    for (int w = 0; w < v.waits; w++) begin
      mem_ack   = 1'b0;
      mem_rdata = 12'hF00;
      @(negedge clk);
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", {24'd0, mem_addr}, {24'd0, mpc});
      chk("wait_ir_hold", {28'd0, Opcode}, {28'd0, prev_op});
    end
    mem_ack   = 1'b1;
    mem_rdata = v.instr;
    e.op   = v.instr[11:8];
    e.opnd = v.instr[7:0];
    e.ra   = v.instr[3:0];
    e.npc  = model_npc(mpc, v);
    sbq.push_back(e);
    @(negedge clk);
    chk("dec_req", {31'd0, mem_req}, 32'd0);
    chk("dec_valid", {31'd0, instr_valid}, 32'd0);
    chk("dec_opcode", {28'd0, Opcode}, {28'd0, e.op});
    chk("dec_operand", {24'd0, Operand}, {24'd0, e.opnd});
    // Ack with junk data outside FETCH must not reload IR.
    mem_rdata = 12'hFFF;
    @(negedge clk);
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("exec_opcode", {28'd0, Opcode}, {28'd0, e.op});
      chk("exec_operand", {24'd0, Operand}, {24'd0, e.opnd});
      chk("exec_regaddr", {28'd0, RegAddr}, {28'd0, e.ra});
    end
    mem_ack   = 1'b0;
    LoadPC    = v.load;
    SelPC     = v.sel;
    IncPC     = v.inc;
    reg_data  = v.rdata;
    @(negedge clk);
    chk("next_pc", {24'd0, pc}, {24'd0, e.npc});
    chk("post_valid", {31'd0, instr_valid}, 32'd0);
    if (e.op == 4'hF) begin
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, mem_req}, 32'd0);
    end else begin
      chk("refetch_req", {31'd0, mem_req}, 32'd1);
      chk("refetch_addr", {24'd0, mem_addr}, {24'd0, e.npc});
    end
    mpc    = e.npc;
    LoadPC = 1'b0;
    SelPC  = 1'b0;
    IncPC  = 1'b0;
  endtask

  initial begin
    //           instr    waits load  sel   inc   rdata
    vecs[0] = '{12'h105, 0, 1'b0, 1'b0, 1'b0, 8'h00};  // basic, pc 0 -> 1
    vecs[1] = '{12'h23A, 4, 1'b1, 1'b0, 1'b0, 8'h00};  // 4 wait cycles, jump imm 0x3A
    vecs[2] = '{12'h300, 1, 1'b1, 1'b1, 1'b0, 8'h77};  // jump reg 0x77
    vecs[3] = '{12'h4C0, 0, 1'b1, 1'b0, 1'b1, 8'h11};  // Load+Inc: jump wins
    vecs[4] = '{12'h5FF, 2, 1'b1, 1'b0, 1'b0, 8'h00};  // to 0xFF
    vecs[5] = '{12'h600, 0, 1'b0, 1'b0, 1'b1, 8'h00};  // 0xFF + 1 wraps to 0
    vecs[6] = '{12'h710, 0, 1'b1, 1'b0, 1'b0, 8'h00};  // to 0x10
    vecs[7] = '{12'h855, 0, 1'b0, 1'b0, 1'b0, 8'h00};  // not-taken, 0x10 -> 0x11
    vecs[8] = '{12'h908, 0, 1'b1, 1'b0, 1'b0, 8'h00};  // to 0x08
    vecs[9] = '{12'hF00, 0, 1'b1, 1'b1, 1'b1, 8'h33};  // halt at 0x08

    #2 CLB = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_opcode", {28'd0, Opcode}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_req", {31'd0, mem_req}, 32'd0);
    #2 CLB = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("first_addr", {24'd0, mem_addr}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    for (int i = 0; i < 22; i++) begin
      mem_ack   = i[0];
      mem_rdata = 12'h105;
      @(negedge clk);
      chk("halt_hold_req", {31'd0, mem_req}, 32'd0);
      chk("halt_hold_flag", {31'd0, halted}, 32'd1);
      chk("halt_hold_pc", {24'd0, pc}, 32'h08);
    end
    mem_ack = 1'b0;

    // Clear pulse in HALT.
    #2 CLB = 1'b0;
    #1;
    chk("clb_halt_flag", {31'd0, halted}, 32'd0);
    chk("clb_halt_pc", {24'd0, pc}, 32'd0);
    chk("clb_halt_req", {31'd0, mem_req}, 32'd0);
    chk("clb_halt_opcode", {28'd0, Opcode}, 32'd0);
    @(negedge clk);
    #2 CLB = 1'b1;
    @(negedge clk);
    chk("restart1_req", {31'd0, mem_req}, 32'd1);
    chk("restart1_addr", {24'd0, mem_addr}, 32'd0);

    // Clear pulse during a FETCH wait with an ack pending.
    mem_ack = 1'b0;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 12'hABC;
    #2 CLB = 1'b0;
    #1;
    chk("clb_fetch_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("clb_fetch_ir", {28'd0, Opcode}, 32'd0);
    chk("clb_fetch_hold_req", {31'd0, mem_req}, 32'd0);
    #2 CLB = 1'b1;
    @(negedge clk);
    chk("restart2_req", {31'd0, mem_req}, 32'd1);
    chk("restart2_addr", {24'd0, mem_addr}, 32'd0);
    chk("restart2_ack_dropped", {28'd0, Opcode}, 32'd0);
    mem_ack = 1'b0;
    mpc     = 8'h00;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, giving the program-counter and jump-target width.
REQ-002 SHALL have parameter IW, default 12, giving the instruction width: opcode is IR[IW-1:IW-4] and operand is IR[PC_W-1:0].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 CLB  input  1  clear, asynchronous and active-low; one clock, reset asynchronous active-low.
REQ-005 mem_req  output  1  instruction-memory read request.
REQ-006 mem_addr  output  PC_W  read address, equal to PC.
REQ-007 mem_ack  input  1  memory has valid data on mem_rdata this cycle.
REQ-008 mem_rdata  input  IW  instruction word.
REQ-009 IncPC  input  1  controller request: PC <= PC+1.
REQ-010 SelPC  input  1  jump source select: 1 = reg_data, 0 = immediate operand.
REQ-011 LoadPC  input  1  controller request: load the jump target into PC.
REQ-012 reg_data  input  PC_W  register-file read value, used as the jump target.
REQ-013 Opcode  output  4  IR[IW-1:IW-4], driven to the controller.
REQ-014 Operand  output  PC_W  IR[PC_W-1:0], the immediate value.
REQ-015 RegAddr  output  4  IR[3:0], the register-file address.
REQ-016 instr_valid  output  1  one-cycle strobe; control inputs are sampled in this cycle.
REQ-017 pc  output  PC_W  current PC.
REQ-018 halted  output  1  high while in HALT.

Function
REQ-019 SHALL implement four states with these transitions:
  - FETCH: mem_req=1; mem_addr=pc. Stays while mem_ack=0; goes to DECODE on mem_req&mem_ack.
  - DECODE: exactly 1 cycle; mem_req=0; Opcode/Operand/RegAddr are valid. Goes to EXEC.
  - EXEC: exactly 1 cycle; instr_valid=1. Goes to HALT if Opcode==4'hF, else to FETCH.
  - HALT: terminal; only CLB exits it.
REQ-020 SHALL load IR from mem_rdata on the edge where FETCH sees mem_ack=1 (internal LoadIR); IR SHALL hold its value at all other times.
REQ-021 SHALL hold mem_addr stable while mem_req=1 and shall ignore mem_ack outside FETCH.
REQ-022 SHALL update PC only on the EXEC edge, using this priority:
  - Opcode==4'hF: PC unchanged.
  - else LoadPC=1: PC <= SelPC ? reg_data : Operand.
  - else IncPC=1: PC <= PC+1.
  - else: PC <= PC+1 (fall-through, covering a not-taken branch or NOP).
REQ-023 PC increment SHALL wrap modulo 2^PC_W, so all-ones becomes 0 with no flag.
REQ-024 LoadPC=1 with IncPC=1 simultaneously SHALL take the LoadPC path.
REQ-025 IncPC, SelPC and LoadPC outside EXEC SHALL have no effect.
REQ-026 Minimum instruction period SHALL be 3 cycles for zero-wait memory, plus 1 cycle per extra FETCH wait cycle.
REQ-027 Outputs SHALL be registered or decoded from state and IR only, with no combinational path from control inputs to outputs.

Reset
REQ-028 CLB=0 SHALL immediately force the following, regardless of state:
  - state=FETCH, pc=0, IR=0;
  - mem_req=0, instr_valid=0, halted=0.
REQ-029 While CLB=0, mem_req SHALL stay 0; on the first rising edge with CLB=1 the unit SHALL enter FETCH and assert mem_req with mem_addr=0.
REQ-030 CLB asserted mid-FETCH, mid-DECODE, mid-EXEC or in HALT SHALL abandon the instruction; a pending mem_ack SHALL be discarded.

Verification
REQ-031 Zero-wait memory returning 0x1_05 at addr 0 -> in DECODE, Opcode=1 and Operand=0x05; instr_valid high in cycle 3; pc=1 after EXEC; mem_req at addr 1 in cycle 4.
REQ-032 mem_ack delayed 4 cycles -> mem_req and mem_addr held constant 4 cycles; IR unchanged until the ack edge; exactly one instr_valid strobe.
REQ-033 EXEC with LoadPC=1, SelPC=0, Operand=0x3A -> next mem_addr=0x3A; with SelPC=1 and reg_data=0x77 -> next mem_addr=0x77; with LoadPC=1 and IncPC=1 -> the jump is taken.
REQ-034 pc=0xFF with IncPC=1 -> pc=0x00; not-taken branch (LoadPC=0, IncPC=0) at pc=0x10 -> pc=0x11.
REQ-035 Opcode 4'hF fetched at pc=0x08 -> halted=1, pc stays 0x08, mem_req stays 0 for 20+ cycles despite mem_ack toggling.
REQ-036 CLB pulsed low during FETCH wait and separately in HALT -> outputs clear asynchronously before the next edge; the unit restarts fetching at addr 0.
